// File: rtl/link_check_counter_pkg.sv
// link_pkg: shared FSM states, width-mode codes and the per-mode compare mask
package link_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, CHECK, FAIL} state_t;

    localparam logic [1:0] MODE_8B  = 2'b00;
    localparam logic [1:0] MODE_16B = 2'b01;
    localparam logic [1:0] MODE_32B = 2'b10;

    // Mode 11 is treated as 32-bit; the caller zero-extends to its own word width
    function automatic logic [31:0] width_mask(input logic [1:0] dataS);
        return dataS == MODE_8B  ? 32'h0000_00FF :
               dataS == MODE_16B ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/link_check_counter_if.sv
// link_check_counter_if: paired receiver streams (reference and DUT) presented to the checker
interface link_check_counter_if #(parameter int DATA_W = 32);

    logic [1:0]        dataS;
    logic              valid;
    logic [DATA_W-1:0] dataRef;
    logic [DATA_W-1:0] dataDut;
    logic              kRef;
    logic              kDut;
    logic              errRef;
    logic              errDut;

    modport master(output dataS, valid, dataRef, dataDut, kRef, kDut, errRef, errDut);
    modport slave (input  dataS, valid, dataRef, dataDut, kRef, kDut, errRef, errDut);

endinterface

// File: rtl/link_check_counter_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc until saturated; clr has the same effect as reset
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (inc && !(&q)) q <= q + W'(1);
    end

endmodule

// File: rtl/link_check_counter.sv
// link_check_counter: locks onto two matching receiver streams, then counts samples and errors
module link_check_counter
    import link_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int SYNC_LEN  = 4,
    parameter int ERR_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  clear,
    link_check_counter_if.slave   lnk,
    output logic                  locked,
    output logic                  fail,
    output logic [CNT_W-1:0]      sampleCount,
    output logic [CNT_W-1:0]      mismatchCount,
    output logic [CNT_W-1:0]      invalidCount,
    output logic [CNT_W-1:0]      kCount,
    output logic [CNT_W-1:0]      firstMisIdx,
    output logic [DATA_W-1:0]     firstMisRef,
    output logic [DATA_W-1:0]     firstMisDut
);

    state_t            state, stateNext;
    logic [7:0]        runLen, runNext;
    logic [DATA_W-1:0] mask;
    logic              mis, clr, go, active, capture;

    assign mask    = DATA_W'(width_mask(lnk.dataS));
    assign mis     = ((lnk.dataRef & mask) != (lnk.dataDut & mask)) ||
                     (lnk.kRef != lnk.kDut) || (lnk.errRef != lnk.errDut);
    assign clr     = enb && clear;
    assign go      = enb && lnk.valid && !clr;
    assign active  = go && (state == CHECK || state == FAIL);
    assign capture = go && state == CHECK && mis && mismatchCount == '0;
    assign locked  = state == CHECK;
    assign fail    = state == FAIL;

    // Next state: IDLE treats its first word as the start of the sync run
    always_comb begin
        stateNext = state;
        runNext   = runLen;
        if (clr) begin
            stateNext = IDLE;
            runNext   = '0;
        end else if (go && (state == IDLE || state == SYNC)) begin
            runNext   = mis ? 8'd0 : (state == IDLE ? 8'd0 : runLen) + 8'd1;
            stateNext = runNext == 8'(SYNC_LEN) ? CHECK : SYNC;
        end else if (go && state == CHECK && mis && mismatchCount == CNT_W'(ERR_LIMIT - 1)) begin
            stateNext = FAIL;
        end
    end

    // State and sync-run registers; enb=0 leaves go/clr low so nothing moves
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            runLen <= '0;
        end else begin
            state  <= stateNext;
            runLen <= runNext;
        end
    end

    // Capture the first mismatching pair after lock; frozen once mismatchCount is non-zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            firstMisIdx <= '0;
            firstMisRef <= '0;
            firstMisDut <= '0;
        end else if (capture) begin
            firstMisIdx <= sampleCount;
            firstMisRef <= lnk.dataRef & mask;
            firstMisDut <= lnk.dataDut & mask;
        end
    end

    sat_counter #(.W(CNT_W)) uSample (.clk(clk), .rst(rst), .clr(clr), .inc(active), .q(sampleCount));
    sat_counter #(.W(CNT_W)) uMis    (.clk(clk), .rst(rst), .clr(clr), .inc(active && mis), .q(mismatchCount));
    sat_counter #(.W(CNT_W)) uInv    (.clk(clk), .rst(rst), .clr(clr), .inc(active && (lnk.errRef || lnk.errDut)), .q(invalidCount));
    sat_counter #(.W(CNT_W)) uK      (.clk(clk), .rst(rst), .clr(clr), .inc(active && lnk.kRef), .q(kCount));

endmodule

// File: tb/tb_link_check_counter.sv
// tb_link_check_counter: directed scenarios plus randomized traffic against a behavioural model
module tb_link_check_counter;

    localparam int DATA_W = 32, CNT_W = 4, SYNC_LEN = 4, ERR_LIMIT = 8;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, enb, clear, locked, fail;
    logic [CNT_W-1:0] sampleCount, mismatchCount, invalidCount, kCount, firstMisIdx;
    logic [DATA_W-1:0] firstMisRef, firstMisDut;
    int checks = 0, errors = 0;

    // Behavioural model: 0 idle, 1 syncing, 2 checking, 3 failed
    int mState, mRun, mSc, mMis, mInv, mK, mIdx;
    logic [31:0] mRef, mDut;

    link_check_counter_if #(.DATA_W(DATA_W)) lnk();

    link_check_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SYNC_LEN(SYNC_LEN), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk(clk), .rst(rst), .enb(enb), .clear(clear), .lnk(lnk.slave),
        .locked(locked), .fail(fail), .sampleCount(sampleCount), .mismatchCount(mismatchCount),
        .invalidCount(invalidCount), .kCount(kCount), .firstMisIdx(firstMisIdx),
        .firstMisRef(firstMisRef), .firstMisDut(firstMisDut)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return v > MAXC ? MAXC : v;
    endfunction

    task automatic modelClear();
        mState = 0; mRun = 0; mSc = 0; mMis = 0; mInv = 0; mK = 0; mIdx = 0; mRef = 0; mDut = 0;
    endtask

    task automatic modelStep();
        logic [31:0] m;
        logic bad;
        if (rst || (enb && clear)) modelClear();
        else if (enb && lnk.valid) begin
            m = lnk.dataS == 2'd0 ? 32'hFF : lnk.dataS == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
            bad = ((lnk.dataRef & m) != (lnk.dataDut & m)) || lnk.kRef != lnk.kDut || lnk.errRef != lnk.errDut;
            if (mState < 2) begin
                mRun = bad ? 0 : (mState == 0 ? 1 : mRun + 1);
                mState = mRun >= SYNC_LEN ? 2 : 1;
            end else begin
                if (mState == 2 && bad && mMis == 0) begin
                    mIdx = mSc; mRef = lnk.dataRef & m; mDut = lnk.dataDut & m;
                end
                mSc = sat(mSc + 1);
                if (bad) mMis = sat(mMis + 1);
                if (lnk.errRef || lnk.errDut) mInv = sat(mInv + 1);
                if (lnk.kRef) mK = sat(mK + 1);
                if (mState == 2 && bad && mMis == ERR_LIMIT) mState = 3;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic word(input logic [31:0] r, input logic [31:0] d, input logic [1:0] s = 2'd2,
                        input logic kr = 1'b0, input logic kd = 1'b0);
        lnk.dataRef = r; lnk.dataDut = d; lnk.dataS = s;
        lnk.kRef = kr; lnk.kDut = kd; lnk.errRef = 1'b0; lnk.errDut = 1'b0;
        lnk.valid = 1'b1;
        step();
        lnk.valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b1; clear = 1'b0;
        lnk.valid = 1'b0; lnk.dataS = 2'd2; lnk.dataRef = '0; lnk.dataDut = '0;
        lnk.kRef = 0; lnk.kDut = 0; lnk.errRef = 0; lnk.errDut = 0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({locked, fail, sampleCount, mismatchCount, invalidCount, kCount, firstMisIdx} !== '0) begin
            errors++; $display("FAIL reset_status got %0h exp 0",
                {locked, fail, sampleCount, mismatchCount, invalidCount, kCount, firstMisIdx});
        end
        checks++;
        if (firstMisRef !== '0) begin errors++; $display("FAIL reset_ref got %0h exp 0", firstMisRef); end
        checks++;
        if (firstMisDut !== '0) begin errors++; $display("FAIL reset_dut got %0h exp 0", firstMisDut); end
    endtask

    task automatic test_lock();
        logic [31:0] w;
        doReset();
        w = $urandom;
        for (int i = 1; i <= 6; i++) begin
            word(w, w);
            if (i == 3) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", locked); end
            end
            if (i == 4) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL lock_4th got %b exp 1", locked); end
            end
        end
        checks++;
        if (sampleCount !== 4'd2) begin errors++; $display("FAIL lock_samples got %0d exp 2", sampleCount); end
    endtask

    task automatic test_mask();
        doReset();
        for (int i = 0; i < 10; i++) word(32'hAAAA_0055, 32'h1234_0055, 2'd0);
        checks++;
        if (mismatchCount !== 4'd0) begin errors++; $display("FAIL mask_mis got %0d exp 0", mismatchCount); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL mask_locked got %b exp 1", locked); end
        checks++;
        if (sampleCount !== 4'd6) begin errors++; $display("FAIL mask_samples got %0d exp 6", sampleCount); end
    endtask

    task automatic test_fail();
        logic [31:0] r, r0;
        r0 = '0;
        for (int i = 1; i <= ERR_LIMIT; i++) begin
            r = $urandom;
            if (i == 1) r0 = r;
            word(r, r ^ 32'h1);
            if (i == ERR_LIMIT - 1) begin
                checks++;
                if (fail !== 1'b0) begin errors++; $display("FAIL fail_early got %b exp 0", fail); end
            end
        end
        checks++;
        if ({fail, locked} !== 2'b10) begin errors++; $display("FAIL fail_state got %b exp 10", {fail, locked}); end
        checks++;
        if (firstMisIdx !== 4'd6) begin errors++; $display("FAIL fail_idx got %0d exp 6", firstMisIdx); end
        checks++;
        if (firstMisRef !== r0) begin errors++; $display("FAIL fail_ref got %h exp %h", firstMisRef, r0); end
        checks++;
        if (firstMisDut !== (r0 ^ 32'h1)) begin errors++; $display("FAIL fail_dut got %h exp %h", firstMisDut, r0 ^ 32'h1); end
        checks++;
        if (mismatchCount !== 4'd8) begin errors++; $display("FAIL fail_mis got %0d exp 8", mismatchCount); end
    endtask

    task automatic test_sync();
        logic [31:0] w;
        doReset();
        w = $urandom;
        for (int i = 0; i < 3; i++) word(w, w);
        word(w, w ^ 32'h100);
        for (int i = 0; i < 3; i++) word(w, w);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL sync_early got %b exp 0", locked); end
        word(w, w);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL sync_lock got %b exp 1", locked); end
    endtask

    task automatic test_saturate();
        logic [31:0] w;
        w = $urandom;
        for (int i = 0; i < 20; i++) word(w, w, 2'd2, 1'b1, 1'b1);
        checks++;
        if (kCount !== 4'hF) begin errors++; $display("FAIL sat_k got %0h exp f", kCount); end
        checks++;
        if (sampleCount !== 4'hF) begin errors++; $display("FAIL sat_samples got %0h exp f", sampleCount); end
    endtask

    task automatic test_clear();
        logic [31:0] w;
        w = $urandom;
        clear = 1'b1;
        word(w, ~w);
        clear = 1'b0;
        checks++;
        if ({locked, fail, sampleCount, mismatchCount, invalidCount, kCount, firstMisIdx} !== '0) begin
            errors++; $display("FAIL clear_zero got %0h exp 0",
                {locked, fail, sampleCount, mismatchCount, invalidCount, kCount, firstMisIdx});
        end
        for (int i = 0; i < 5; i++) word(w, w);
        checks++;
        if (sampleCount !== 4'd1) begin errors++; $display("FAIL clear_relock got %0d exp 1", sampleCount); end
        rst = 1'b1; clear = 1'b1;
        step();
        rst = 1'b0; clear = 1'b0;
        checks++;
        if ({locked, sampleCount} !== '0) begin errors++; $display("FAIL rst_clear got %0h exp 0", {locked, sampleCount}); end
        for (int i = 0; i < 4; i++) word(w, w);
        word(w, w ^ 32'h8000_0000);
        enb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lnk.valid = i[0]; lnk.dataRef = $urandom; lnk.dataDut = $urandom; clear = i[1];
            step();
            checks++;
            if ({locked, sampleCount, mismatchCount, firstMisIdx} !== {mState == 2, CNT_W'(mSc), CNT_W'(mMis), CNT_W'(mIdx)}) begin
                errors++; $display("FAIL enb_hold got %0h exp %0h", {locked, sampleCount, mismatchCount, firstMisIdx},
                    {mState == 2, CNT_W'(mSc), CNT_W'(mMis), CNT_W'(mIdx)});
            end
        end
        enb = 1'b1; clear = 1'b0; lnk.valid = 1'b0;
        checks++;
        if ({locked, mismatchCount, firstMisDut} !== {1'b1, 4'd1, w ^ 32'h8000_0000}) begin
            errors++; $display("FAIL enb_const got %0h exp %0h", {locked, mismatchCount, firstMisDut}, {1'b1, 4'd1, w ^ 32'h8000_0000});
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 800; i++) begin
            rst = $urandom_range(99) == 0;
            enb = $urandom_range(7) != 0;
            clear = $urandom_range(59) == 0;
            lnk.valid = $urandom_range(3) != 0;
            lnk.dataS = 2'($urandom);
            r = $urandom;
            lnk.dataRef = r;
            lnk.dataDut = $urandom_range(9) == 0 ? $urandom : ($urandom_range(3) == 0 ? r ^ ($urandom & 32'hFFFF_0000) : r);
            lnk.kRef = $urandom_range(4) == 0;
            lnk.kDut = $urandom_range(39) == 0 ? ~lnk.kRef : lnk.kRef;
            lnk.errRef = $urandom_range(9) == 0;
            lnk.errDut = $urandom_range(39) == 0 ? ~lnk.errRef : lnk.errRef;
            step();
            checks++;
            if (locked !== (mState == 2)) begin errors++; $display("FAIL rnd_locked cyc %0d got %b exp %b", i, locked, mState == 2); end
            checks++;
            if (fail !== (mState == 3)) begin errors++; $display("FAIL rnd_fail cyc %0d got %b exp %b", i, fail, mState == 3); end
            checks++;
            if (sampleCount !== CNT_W'(mSc)) begin errors++; $display("FAIL rnd_samples cyc %0d got %0d exp %0d", i, sampleCount, mSc); end
            checks++;
            if (mismatchCount !== CNT_W'(mMis)) begin errors++; $display("FAIL rnd_mis cyc %0d got %0d exp %0d", i, mismatchCount, mMis); end
            checks++;
            if (invalidCount !== CNT_W'(mInv)) begin errors++; $display("FAIL rnd_inv cyc %0d got %0d exp %0d", i, invalidCount, mInv); end
            checks++;
            if (kCount !== CNT_W'(mK)) begin errors++; $display("FAIL rnd_k cyc %0d got %0d exp %0d", i, kCount, mK); end
            checks++;
            if (firstMisIdx !== CNT_W'(mIdx)) begin errors++; $display("FAIL rnd_idx cyc %0d got %0d exp %0d", i, firstMisIdx, mIdx); end
            checks++;
            if (firstMisRef !== mRef) begin errors++; $display("FAIL rnd_ref cyc %0d got %h exp %h", i, firstMisRef, mRef); end
            checks++;
            if (firstMisDut !== mDut) begin errors++; $display("FAIL rnd_dut cyc %0d got %h exp %h", i, firstMisDut, mDut); end
        end
        rst = 1'b0; clear = 1'b0; enb = 1'b1; lnk.valid = 1'b0;
    endtask

    initial begin
        modelClear();
        test_reset();
        test_lock();
        test_mask();
        test_fail();
        test_sync();
        test_saturate();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
